alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Sequencing front end for the 32-bit combinational ALU; it is the initiator side of the ALU operand/command interface.
- It takes requests over a valid/ready handshake and drives operandA/operandB/command into the ALU.
- It captures result/carryout/zero/overflow and returns them over a valid/ready response channel.
- It also runs multi-cycle unsigned multiply, divide and remainder by iterating ALU ADD/SUB, one iteration per cycle.

Parameters:
- WIDTH, 32, datapath width; must match the ALU.
- CNT_W, 5, iteration counter width; equals log2(WIDTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_op  input  2  00 SINGLE, 01 MULU (low word), 10 DIVU (quotient), 11 REMU (remainder).
- req_cmd  input  3  ALU command for SINGLE: 000 add, 001 sub, 010 xor, 011 slt, 100 and, 101 nand, 110 nor, 111 or.
- req_a  input  WIDTH  operand A / dividend / multiplicand.
- req_b  input  WIDTH  operand B / divisor / multiplier.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  WIDTH  result.
- rsp_carryout  output  1  ALU carryout (SINGLE only, else 0).
- rsp_zero  output  1  ALU zero for SINGLE; for MULU/DIVU/REMU, (rsp_result==0).
- rsp_overflow  output  1  ALU overflow (SINGLE only, else 0).
- rsp_divzero  output  1  DIVU/REMU issued with req_b==0.
- alu_operandA  output  WIDTH  to ALU.
- alu_operandB  output  WIDTH  to ALU.
- alu_command  output  3  to ALU.
- alu_result  input  WIDTH  from ALU.
- alu_carryout  input  1  from ALU.
- alu_zero  input  1  from ALU.
- alu_overflow  input  1  from ALU.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset, effective immediately, including mid-operation: state=IDLE, req_ready=1, rsp_valid=0, all rsp_* =0, alu_* =0. An in-flight operation is discarded.
- States: IDLE, EXEC, ITER, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid at edge k, latch op/cmd/a/b.
  - SINGLE goes to EXEC.
  - MULU goes to ITER with count=0.
  - DIVU/REMU with b!=0 goes to ITER.
  - DIVU/REMU with b==0 goes straight to DONE: result=32'hFFFFFFFF for DIVU, a for REMU, rsp_divzero=1.
- ALU drive:
  - In IDLE/DONE: alu_command=000 and both operands 0.
  - ALU outputs are used combinationally within the same cycle; no ALU pipelining.
- EXEC:
  - Drive the latched a, b, cmd for one cycle.
  - Capture alu_result/carryout/zero/overflow at the next edge and go to DONE.
  - rsp_valid rises after edge k+1.
- ITER MULU, registers acc=0, mc=a, mp=b:
  - Each cycle drive ADD(acc, mc).
  - At the edge: acc<=alu_result if mp[0], else unchanged; mc<=mc<<1; mp<=mp>>1; count++.
  - Result is acc mod 2^32.
- ITER DIVU/REMU, registers r=0, q=a:
  - Shifted remainder rs={r[30:0],q[31]}; top bit t=r[31].
  - Drive SUB(rs, b).
  - ge = t | alu_carryout. This is valid because b!=0, so the ALU carryout means rs>=b unsigned.
  - At the edge: r<=ge?alu_result:rs; q<={q[30:0],ge}; count++.
- Exit from ITER: after the edge where count==31, go to DONE (32 iterations). rsp_valid rises after edge k+32.
- DONE:
  - rsp_valid=1; all rsp_* held stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready, go to IDLE and drop rsp_valid at that edge.
  - req_ready reasserts the following cycle; no same-cycle back-to-back issue.
- Ignored inputs:
  - req_valid is ignored outside IDLE.
  - req_cmd is ignored for non-SINGLE ops.
  - Inputs do not need to be held after acceptance.

Decomposition:
- Shared package alu_pkg holds:
  - ALU command localparams (CMD_ADD..CMD_OR).
  - req_op enum (OP_SINGLE, OP_MULU, OP_DIVU, OP_REMU).
  - State enum.
  - WIDTH default.
- The ALU is instantiated outside this block; the controller only owns the interface.
- No sub-module; one FSM with an iteration datapath.

Test Plan:
- SINGLE sub, a=5, b=7 -> ALU sees cmd 001 for exactly 1 cycle; rsp_result=32'hFFFFFFFE, carryout=0, zero=0; rsp_valid 1 cycle after acceptance.
- SINGLE add, a=32'h7FFFFFFF, b=1 -> result=32'h80000000, overflow=1, carryout=0. Then add FFFFFFFF+1 -> result=0, carryout=1, zero=1.
- MULU a=12345, b=6789 -> result=83810205, rsp_valid exactly 32 cycles after acceptance. MULU FFFFFFFF×FFFFFFFF -> 1.
- DIVU a=100, b=7 -> 14; REMU same operands -> 2. DIVU a=FFFFFFFF, b=80000001 -> 1 and REMU -> 7FFFFFFE, exercising the t=1 path.
- DIVU b=0, a=9 -> 1 cycle latency, result=FFFFFFFF, divzero=1. REMU b=0 -> result=9.
- Backpressure and reset:
  - rsp_ready held low 5 cycles -> rsp_* stable, req_ready=0, new req_valid ignored.
  - rst_n low mid-MULU -> rsp_valid=0, req_ready=1 immediately.
  - Next request completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 32-bit ALU and its sequencing controller:
//   - ALU_WIDTH  : default datapath width of the ALU
//   - CMD_*      : 3-bit ALU command encodings
//   - op_e       : request operation codes accepted by alu_seq_ctrl
//   - state_e    : controller FSM states
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [2:0] CMD_ADD  = 3'b000;
  localparam logic [2:0] CMD_SUB  = 3'b001;
  localparam logic [2:0] CMD_XOR  = 3'b010;
  localparam logic [2:0] CMD_SLT  = 3'b011;
  localparam logic [2:0] CMD_AND  = 3'b100;
  localparam logic [2:0] CMD_NAND = 3'b101;
  localparam logic [2:0] CMD_NOR  = 3'b110;
  localparam logic [2:0] CMD_OR   = 3'b111;

  typedef enum logic [1:0] {
    OP_SINGLE = 2'b00,
    OP_MULU   = 2'b01,
    OP_DIVU   = 2'b10,
    OP_REMU   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_ITER = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
// Sequencing front end for an external combinational ALU. Accepts requests
// over a valid/ready channel, drives the ALU operand/command interface and
// returns result plus flags over a valid/ready response channel. SINGLE ops
// take one ALU cycle; MULU/DIVU/REMU iterate ALU ADD/SUB for WIDTH cycles.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_op, req_cmd            operation and ALU command (SINGLE only)
//   req_a, req_b               operands
//   rsp_valid/rsp_ready        response handshake
//   rsp_result, rsp_carryout,
//   rsp_zero, rsp_overflow,
//   rsp_divzero                response payload
//   alu_operandA/B, alu_command  drive to the ALU
//   alu_result, alu_carryout,
//   alu_zero, alu_overflow     returned from the ALU (same cycle)
// ---------------------------------------------------------------------------
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [2:0]       req_cmd,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carryout,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_divzero,
  output logic [WIDTH-1:0] alu_operandA,
  output logic [WIDTH-1:0] alu_operandB,
  output logic [2:0]       alu_command,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_zero,
  input  logic             alu_overflow
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [2:0]       cmd_q, cmd_d;
  // opa: operand A / multiplicand (mc) / dividend-quotient shift reg (q)
  // opb: operand B / multiplier (mp) / divisor
  // acc: product accumulator / partial remainder (r)
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             divz_q, divz_d;

  logic [WIDTH-1:0] remShift;
  logic             remGe;
  logic [WIDTH-1:0] finalRes;

  // Division step: shift the next dividend bit into the partial remainder.
  // The bit shifted out of r makes rs a WIDTH+1 bit value, so rs >= b holds
  // whenever that bit is set, regardless of the ALU subtraction carry.
  assign remShift = {acc_q[WIDTH-2:0], opa_q[WIDTH-1]};
  assign remGe    = acc_q[WIDTH-1] | alu_carryout;

  assign req_ready    = (state_q == S_IDLE);
  assign rsp_valid    = (state_q == S_DONE);
  assign rsp_result   = res_q;
  assign rsp_carryout = carry_q;
  assign rsp_zero     = zero_q;
  assign rsp_overflow = ovf_q;
  assign rsp_divzero  = divz_q;

  // ALU drive: quiet (ADD 0,0) except while executing or iterating.
  always_comb begin
    alu_operandA = '0;
    alu_operandB = '0;
    alu_command  = CMD_ADD;
    case (state_q)
      S_EXEC: begin
        alu_operandA = opa_q;
        alu_operandB = opb_q;
        alu_command  = cmd_q;
      end
      S_ITER: begin
        if (op_q == OP_MULU) begin
          alu_operandA = acc_q;
          alu_operandB = opa_q;
          alu_command  = CMD_ADD;
        end else begin
          alu_operandA = remShift;
          alu_operandB = opb_q;
          alu_command  = CMD_SUB;
        end
      end
      default: ;
    endcase
  end

  // Next-state and datapath update for all four states.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cmd_d    = cmd_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    divz_d   = divz_q;
    finalRes = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = op_e'(req_op);
          cmd_d   = req_cmd;
          opa_d   = req_a;
          opb_d   = req_b;
          acc_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          divz_d  = 1'b0;
          case (op_e'(req_op))
            OP_SINGLE: state_d = S_EXEC;
            OP_MULU:   state_d = S_ITER;
            default: begin
              if (req_b == '0) begin
                // Divide by zero short-circuits with RISC-V style results.
                finalRes = (op_e'(req_op) == OP_DIVU) ? '1 : req_a;
                res_d    = finalRes;
                zero_d   = (finalRes == '0);
                divz_d   = 1'b1;
                state_d  = S_DONE;
              end else begin
                state_d = S_ITER;
              end
            end
          endcase
        end
      end
      S_EXEC: begin
        res_d   = alu_result;
        carry_d = alu_carryout;
        zero_d  = alu_zero;
        ovf_d   = alu_overflow;
        state_d = S_DONE;
      end
      S_ITER: begin
        if (op_q == OP_MULU) begin
          if (opb_q[0]) acc_d = alu_result;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end else begin
          acc_d = remGe ? alu_result : remShift;
          opa_d = {opa_q[WIDTH-2:0], remGe};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          finalRes = (op_q == OP_DIVU) ? opa_d : acc_d;
          res_d    = finalRes;
          zero_d   = (finalRes == '0);
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_SINGLE;
      cmd_q   <= CMD_ADD;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cmd_q   <= cmd_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      divz_q  <= divz_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl
// Directed testbench for alu_seq_ctrl with a behavioural 32-bit ALU attached
// to the operand/command interface. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [2:0]  req_cmd = 3'b000;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_carryout;
  logic        rsp_zero;
  logic        rsp_overflow;
  logic        rsp_divzero;
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [2:0]  alu_command;
  logic [31:0] alu_result;
  logic        alu_carryout;
  logic        alu_zero;
  logic        alu_overflow;

  int testsRun = 0;
  int testsFailed = 0;
  int latency;
  int subSeen;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carryout(rsp_carryout),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .rsp_divzero(rsp_divzero),
    .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
    .alu_command(alu_command), .alu_result(alu_result),
    .alu_carryout(alu_carryout), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow)
  );

  // Behavioural ALU: carryout on SUB means no borrow (A >= B unsigned).
  logic [32:0] aluSum;
  always_comb begin
    aluSum       = '0;
    alu_result   = '0;
    alu_carryout = 1'b0;
    alu_overflow = 1'b0;
    case (alu_command)
      CMD_ADD: begin
        aluSum       = {1'b0, alu_operandA} + {1'b0, alu_operandB};
        alu_result   = aluSum[31:0];
        alu_carryout = aluSum[32];
        alu_overflow = (alu_operandA[31] == alu_operandB[31]) &&
                       (aluSum[31] != alu_operandA[31]);
      end
      CMD_SUB: begin
        aluSum       = {1'b0, alu_operandA} + {1'b0, ~alu_operandB} + 33'd1;
        alu_result   = aluSum[31:0];
        alu_carryout = aluSum[32];
        alu_overflow = (alu_operandA[31] != alu_operandB[31]) &&
                       (aluSum[31] != alu_operandA[31]);
      end
      CMD_XOR:  alu_result = alu_operandA ^ alu_operandB;
      CMD_SLT:  alu_result = {31'b0, $signed(alu_operandA) < $signed(alu_operandB)};
      CMD_AND:  alu_result = alu_operandA & alu_operandB;
      CMD_NAND: alu_result = ~(alu_operandA & alu_operandB);
      CMD_NOR:  alu_result = ~(alu_operandA | alu_operandB);
      default:  alu_result = alu_operandA | alu_operandB;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  // Single checking point: counts every comparison and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Issue one request, scramble the inputs after acceptance and wait for the
  // response, recording latency (edges after acceptance) and SUB cycles seen.
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] cmd,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    checkOutput("req_ready before issue", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_cmd   = cmd;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'b01;
    req_cmd   = 3'b111;
    req_a     = 32'hDEADBEEF;
    req_b     = 32'h0BADF00D;
    latency   = 0;
    subSeen   = 0;
    while (!rsp_valid && latency < 200) begin
      if (alu_command == CMD_SUB) subSeen++;
      @(posedge clk);
      #1;
      latency++;
    end
    if (!rsp_valid) checkOutput("response timeout", {31'b0, rsp_valid}, 32'd1);
  endtask

  task automatic checkResponse(input string tag, input logic [31:0] res,
                               input logic c, input logic z, input logic o,
                               input logic dz);
    checkOutput({tag, " result"},   rsp_result, res);
    checkOutput({tag, " carryout"}, {31'b0, rsp_carryout}, {31'b0, c});
    checkOutput({tag, " zero"},     {31'b0, rsp_zero}, {31'b0, z});
    checkOutput({tag, " overflow"}, {31'b0, rsp_overflow}, {31'b0, o});
    checkOutput({tag, " divzero"},  {31'b0, rsp_divzero}, {31'b0, dz});
  endtask

  task automatic popResponse(input string tag);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput({tag, " rsp_valid drop"}, {31'b0, rsp_valid}, 32'd0);
    checkOutput({tag, " req_ready back"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    checkOutput("reset req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("reset rsp_result", rsp_result, 32'd0);
    checkOutput("reset alu_command", {29'b0, alu_command}, 32'd0);
    checkOutput("reset alu_operandA", alu_operandA, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // SINGLE sub 5-7
    applyStimulus(OP_SINGLE, CMD_SUB, 32'd5, 32'd7);
    checkOutput("sub latency", latency, 32'd1);
    checkOutput("sub alu cycles", subSeen, 32'd1);
    checkResponse("sub", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("done alu_command", {29'b0, alu_command}, 32'd0);
    checkOutput("done alu_operandB", alu_operandB, 32'd0);
    popResponse("sub");

    // SINGLE add overflow, then carry/zero
    applyStimulus(OP_SINGLE, CMD_ADD, 32'h7FFFFFFF, 32'd1);
    checkResponse("add ovf", 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0);
    popResponse("add ovf");
    applyStimulus(OP_SINGLE, CMD_ADD, 32'hFFFFFFFF, 32'd1);
    checkResponse("add carry", 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);
    popResponse("add carry");

    // SINGLE slt, signed -1 < 1
    applyStimulus(OP_SINGLE, CMD_SLT, 32'hFFFFFFFF, 32'd1);
    checkResponse("slt", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    popResponse("slt");

    // MULU
    applyStimulus(OP_MULU, CMD_SUB, 32'd12345, 32'd6789);
    checkOutput("mulu latency", latency, 32'd32);
    checkResponse("mulu", 32'd83810205, 1'b0, 1'b0, 1'b0, 1'b0);
    popResponse("mulu");
    applyStimulus(OP_MULU, CMD_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checkResponse("mulu max", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    popResponse("mulu max");
    applyStimulus(OP_MULU, CMD_ADD, 32'd0, 32'd5);
    checkResponse("mulu zero", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    popResponse("mulu zero");

    // DIVU / REMU
    applyStimulus(OP_DIVU, CMD_ADD, 32'd100, 32'd7);
    checkOutput("divu latency", latency, 32'd32);
    checkResponse("divu", 32'd14, 1'b0, 1'b0, 1'b0, 1'b0);
    popResponse("divu");
    applyStimulus(OP_REMU, CMD_ADD, 32'd100, 32'd7);
    checkResponse("remu", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    popResponse("remu");
    applyStimulus(OP_DIVU, CMD_ADD, 32'hFFFFFFFF, 32'h80000001);
    checkResponse("divu top", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    popResponse("divu top");
    applyStimulus(OP_REMU, CMD_ADD, 32'hFFFFFFFF, 32'h80000001);
    checkResponse("remu top", 32'h7FFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    popResponse("remu top");

    // Divide by zero goes straight to DONE at the acceptance edge
    applyStimulus(OP_DIVU, CMD_ADD, 32'd9, 32'd0);
    checkOutput("divz latency", latency, 32'd0);
    checkResponse("divu by 0", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    popResponse("divu by 0");
    applyStimulus(OP_REMU, CMD_ADD, 32'd9, 32'd0);
    checkResponse("remu by 0", 32'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    popResponse("remu by 0");

    // Backpressure: response held, new requests ignored
    applyStimulus(OP_SINGLE, CMD_XOR, 32'hF0F0F0F0, 32'h0FF00FF0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OP_MULU;
      req_a     = 32'd3;
      req_b     = 32'd3;
      checkOutput("bp rsp_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("bp rsp_result", rsp_result, 32'hFF00FF00);
      checkOutput("bp req_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    popResponse("bp");
    repeat (3) @(negedge clk);
    checkOutput("bp no phantom", {31'b0, rsp_valid}, 32'd0);

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_MULU;
    req_a     = 32'd7;
    req_b     = 32'd9;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("midrst req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("midrst alu_operandB", alu_operandB, 32'd0);
    checkOutput("midrst rsp_result", rsp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Next request after reset completes normally
    applyStimulus(OP_MULU, CMD_ADD, 32'd3, 32'd5);
    checkOutput("post-rst latency", latency, 32'd32);
    checkResponse("post-rst mulu", 32'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    popResponse("post-rst");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
